// File: rtl/sdram_responder.sv
// sdram_responder: synthesizable SDRAM device model answering a W9864G6JT-style
// controller. It decodes commands, tracks per-bank row state and the mode
// register, stores data in an on-chip word array and returns read data after
// the programmed CAS latency.
// Optional feature macro: SDRAM_RESP_CHECK_EN enables the tRCD counters and the
// sticky protocol error flags on err; without it err is tied to zero.
module sdram_responder #(
    parameter int unsigned ROW_BITS = 4,
    parameter int unsigned TRCD     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sdram_cke,
    input  logic        sdram_ncs,
    input  logic        sdram_nras,
    input  logic        sdram_ncas,
    input  logic        sdram_nwe,
    input  logic [1:0]  sdram_ba,
    input  logic [11:0] sdram_a,
    input  logic        sdram_dqml,
    input  logic        sdram_dqmh,
    input  logic [15:0] dq_i,
    output logic [15:0] dq_o,
    output logic [1:0]  dq_oe,
    output logic        mode_valid,
    output logic [2:0]  err
);

    localparam int unsigned BANKS    = 4;
    localparam int unsigned COL_BITS = 8;
    localparam int unsigned AW       = 2 + ROW_BITS + COL_BITS;
    localparam int unsigned DEPTH    = 2 ** AW;

    typedef enum logic [2:0] {
        CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF, CMD_MRS
    } cmd_t;

    // A zero entry means "no read in this slot"
    typedef struct packed {
        logic [1:0]  be;
        logic [15:0] data;
    } rd_ent_t;

    cmd_t                               cmd;
    logic [BANKS-1:0]                   bank_act, act_nxt;
    logic [BANKS-1:0][ROW_BITS-1:0]     bank_row, row_nxt;
    logic [2:0]                         cl_q, cl_nxt, cl_eff;
    logic                               mode_valid_nxt;
    logic [2:0]                         err_set;
    logic                               acc_en;
    logic [AW-1:0]                      mem_idx;
    logic [15:0]                        mem [DEPTH];
    rd_ent_t                            rd_ent, pipe_s0, pipe_s1;
    logic                               unused_ok;

`ifdef SDRAM_RESP_CHECK_EN
    localparam int unsigned CNT_W = (TRCD > 1) ? $clog2(TRCD) : 1;
    logic [BANKS-1:0][CNT_W-1:0] trcd_cnt;
`endif

    // Address bits that no command of this device looks at
    assign unused_ok = ^{sdram_a[11], sdram_a[9:8]};

    // Command decode; deselect or cke low reads as NOP
    always_comb begin
        cmd = CMD_NOP;
        if (sdram_cke && !sdram_ncs) begin
            case ({sdram_nras, sdram_ncas, sdram_nwe})
                3'b011:  cmd = CMD_ACT;
                3'b101:  cmd = CMD_RD;
                3'b100:  cmd = CMD_WR;
                3'b010:  cmd = CMD_PRE;
                3'b001:  cmd = CMD_REF;
                3'b000:  cmd = CMD_MRS;
                default: cmd = CMD_NOP;
            endcase
        end
    end

    // Word index of the addressed column in the currently open row
    assign mem_idx = {sdram_ba, bank_row[sdram_ba], sdram_a[COL_BITS-1:0]};
    assign cl_eff  = mode_valid ? cl_q : 3'd2;

    // Next bank/mode state and error events for the sampled command
    always_comb begin
        act_nxt        = bank_act;
        row_nxt        = bank_row;
        cl_nxt         = cl_q;
        mode_valid_nxt = mode_valid;
        err_set        = 3'b000;
        acc_en         = 1'b0;
        case (cmd)
            CMD_ACT: begin
                if (bank_act[sdram_ba]) begin
                    err_set[0] = 1'b1;
                end else begin
                    act_nxt[sdram_ba] = 1'b1;
                    row_nxt[sdram_ba] = sdram_a[ROW_BITS-1:0];
                end
            end
            CMD_RD, CMD_WR: begin
                if (!bank_act[sdram_ba]) begin
                    err_set[0] = 1'b1;
                end else begin
                    acc_en = 1'b1;
`ifdef SDRAM_RESP_CHECK_EN
                    if (trcd_cnt[sdram_ba] != '0) err_set[1] = 1'b1;
`endif
                    if (!mode_valid) err_set[2] = 1'b1;
                    if (sdram_a[10]) act_nxt[sdram_ba] = 1'b0;
                end
            end
            CMD_PRE: begin
                if (sdram_a[10]) act_nxt = '0;
                else             act_nxt[sdram_ba] = 1'b0;
            end
            CMD_REF: begin
                if (|bank_act) err_set[0] = 1'b1;
            end
            CMD_MRS: begin
                if (|bank_act) begin
                    err_set[0] = 1'b1;
                end else if ((sdram_a[6:4] == 3'd2 || sdram_a[6:4] == 3'd3) &&
                             sdram_a[2:0] == 3'b000) begin
                    cl_nxt         = sdram_a[6:4];
                    mode_valid_nxt = 1'b1;
                end else begin
                    mode_valid_nxt = 1'b0;
                    err_set[2]     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Bank and mode register state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_act   <= '0;
            bank_row   <= '0;
            cl_q       <= 3'd2;
            mode_valid <= 1'b0;
        end else begin
            bank_act   <= act_nxt;
            bank_row   <= row_nxt;
            cl_q       <= cl_nxt;
            mode_valid <= mode_valid_nxt;
        end
    end

`ifdef SDRAM_RESP_CHECK_EN
    // tRCD countdown per bank, reloaded by an accepted ACTIVE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trcd_cnt <= '0;
        end else begin
            for (int b = 0; b < BANKS; b++) begin
                if (act_nxt[b] && !bank_act[b]) begin
                    trcd_cnt[b] <= CNT_W'(TRCD - 1);
                end else if (trcd_cnt[b] != '0) begin
                    trcd_cnt[b] <= trcd_cnt[b] - CNT_W'(1);
                end
            end
        end
    end

    // Sticky protocol error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 3'b000;
        else        err <= err | err_set;
    end
`else
    logic unused_chk;
    assign unused_chk = (^err_set) ^ (TRCD != 0);
    assign err        = 3'b000;
`endif

    // Byte-masked array write at the command edge (contents survive reset)
    always_ff @(posedge clk) begin
        if (acc_en && cmd == CMD_WR) begin
            if (!sdram_dqml) mem[mem_idx][7:0]  <= dq_i[7:0];
            if (!sdram_dqmh) mem[mem_idx][15:8] <= dq_i[15:8];
        end
    end

    // Read entry captured at the command edge
    always_comb begin
        rd_ent.be   = ~{sdram_dqmh, sdram_dqml};
        rd_ent.data = mem[mem_idx];
    end

    // CAS latency pipeline: CL=3 enters s0, CL=2 enters s1, s1 feeds the pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_s0 <= '0;
            pipe_s1 <= '0;
            dq_o    <= 16'h0000;
            dq_oe   <= 2'b00;
        end else begin
            pipe_s0 <= (acc_en && cmd == CMD_RD && cl_eff == 3'd3) ? rd_ent : '0;
            pipe_s1 <= (acc_en && cmd == CMD_RD && cl_eff == 3'd2) ? rd_ent : pipe_s0;
            dq_o    <= pipe_s1.data;
            dq_oe   <= pipe_s1.be;
        end
    end

endmodule

// File: doc/sdram_responder.md
# sdram_responder

Synthesizable SDRAM device model that answers the command stream produced by the design's SDRAM controller on the Winbond W9864G6JT-style pin interface. It decodes chip-select/RAS/CAS/WE commands, tracks per-bank row state and the mode register, stores data in an on-chip word array, and returns read data after the programmed CAS latency. It sits in simulation and FPGA self-test builds in place of the physical chip, and flags protocol violations by the controller.

## Interface
- ROW_BITS, 4: low row-address bits kept; array depth = 4 banks × 2^ROW_BITS rows × 256 columns × 16 bit.
- TRCD, 2: minimum cycles from ACTIVE to READ/WRITE on the same bank.
- clk  in  1  SDRAM clock; all sampling on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sdram_cke  in  1  clock enable; low = command ignored.
- sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe  in  1 each  command pins.
- sdram_ba  in  2  bank address.
- sdram_a  in  12  multiplexed address.
- sdram_dqml, sdram_dqmh  in  1 each  byte masks (high = masked).
- dq_i  in  16  data from controller.
- dq_o  out  16  read data toward controller.
- dq_oe  out  2  per-byte output enable ([1]=high byte).
- mode_valid  out  1  a LOAD_MODE with supported settings has been accepted.
- err  out  3  sticky protocol error flags.

## Operation
- Command = {ncs,nras,ncas,nwe}, decoded only when cke=1 and ncs=0: 0011 ACTIVE, 0101 READ, 0100 WRITE, 0010 PRECHARGE, 0001 AUTO_REFRESH, 0000 LOAD_MODE, 0111/0110/others NOP.
- LOAD_MODE: latch CL=a[6:4]; accept if CL∈{2,3} and a[2:0]=000, else mode_valid=0 and err[2]=1. Latched only when all banks idle, else err[0].
- Per bank state: IDLE/ACTIVE plus open row (ROW_BITS) and a tRCD counter loaded with TRCD-1 at ACTIVE, saturating at 0.
- ACTIVE: bank IDLE→ACTIVE, row=a[ROW_BITS-1:0]; ACTIVE to active bank → err[0], row unchanged.
- READ/WRITE: column=a[7:0]; word index {ba,row,col}. Target bank IDLE → err[0], no access, no data. Counter ≠0 → err[1], access still performed. mode_valid=0 → err[2], access still performed with CL=2.
- WRITE: dq_i[7:0] stored unless dqml, dq_i[15:8] unless dqmh, at the command edge.
- READ: array read at command edge; byte enables = ~{dqmh,dqml} sampled with command; entry pushed into CL pipeline.
- a[10]=1 on READ/WRITE: bank returns to IDLE after the access (auto-precharge).
- PRECHARGE: a[10]=1 all banks IDLE, else bank ba only; precharging an idle bank is legal.
- AUTO_REFRESH: legal only with all banks IDLE, else err[0]; no array effect.
- err bits sticky until rst_n.

## Timing
- Reset (async assert): all banks IDLE, counters 0, CL=2, mode_valid=0, err=0, pipeline empty, dq_o=0, dq_oe=0. Array contents not reset.
- READ sampled at edge T: dq_o/dq_oe registered at edge T+CL-1, held one cycle, so controller samples valid data at edge T+CL; otherwise dq_oe=0, dq_o=0.
- Back-to-back READs every cycle produce data every cycle; pipeline depth 3.
- WRITE at edge T then READ same word at T+1 returns new data.
- WRITE issued while read data pending: pending data still driven (bus contention is the controller's fault, not flagged).
- rst_n asserted mid-read: pending data discarded, dq_oe=0 immediately.
- ACTIVE at T, READ at T+TRCD: legal; READ at T+TRCD-1: err[1].
- Row bits above ROW_BITS ignored (aliasing).

## Configuration
- SDRAM_RESP_CHECK_EN defined: err tRCD counters and all checks present as above.
- Undefined: err tied 0, counters removed; accesses to IDLE banks still return no data; unsupported mode still clears mode_valid.

## Test plan
- Reset, LOAD_MODE a=0x220 (CL=2) -> mode_valid=1, err=0.
- ACTIVE bank1 row5, WRITE col 0x12 data 0xA55A both bytes, READ same -> dq_o=0xA55A, dq_oe=11 at edge READ+2.
- WRITE 0x1234 with dqmh=1 over 0xFFFF then READ -> 0xFF34; READ with dqml=1 -> dq_oe=10.
- LOAD_MODE CL=3, four consecutive READs cols 0..3 -> four data words on consecutive cycles starting at edge +3.
- READ to idle bank -> err[0]=1, dq_oe stays 0; READ one cycle after ACTIVE with TRCD=2 -> err[1]=1.
- READ with a[10]=1 then AUTO_REFRESH -> err=0; rst_n low 1 cycle after READ -> dq_oe=0, no data.
